// File: rtl/ad7606_emu.sv
// Device-side model of the AD7606 parallel ADC: power-up, reset, CONVST/BUSY
// conversions and an eight-channel CS/RD read port with FRSTDATA.
module ad7606_emu #(
  parameter int POWERUP_TICKS   = 30,
  parameter int RESET_MIN_TICKS = 2,
  parameter int CONV_TICKS      = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stby,
  input  logic        reset,
  input  logic        convst,
  input  logic        cs_n,
  input  logic        rd_n,
  output logic        busy,
  output logic        frstdata,
  output logic [15:0] db,
  output logic        db_oe
);

  localparam int PW = $clog2(POWERUP_TICKS) + 1;
  localparam int CW = $clog2(CONV_TICKS) + 1;
  localparam int RW = $clog2(RESET_MIN_TICKS) + 1;

  localparam logic [2:0] ST_OFF        = 3'd0;
  localparam logic [2:0] ST_POWERING   = 3'd1;
  localparam logic [2:0] ST_WAIT_RESET = 3'd2;
  localparam logic [2:0] ST_IDLE       = 3'd3;
  localparam logic [2:0] ST_CONVERTING = 3'd4;

  logic [2:0]    stby_sync_q, stby_sync_d;
  logic [2:0]    reset_sync_q, reset_sync_d;
  logic [2:0]    convst_sync_q, convst_sync_d;
  logic [2:0]    cs_sync_q, cs_sync_d;
  logic [2:0]    rd_sync_q, rd_sync_d;

  logic [2:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          frstdata_q, frstdata_d;
  logic [15:0]   db_q, db_d;
  logic          db_oe_q, db_oe_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [12:0]   conv_count_q, conv_count_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [PW-1:0] power_cnt_q, power_cnt_d;
  logic [RW-1:0] reset_w_q, reset_w_d;
  logic [15:0]   ch_q [8];
  logic [15:0]   ch_d [8];

  logic stby_s, reset_s, reset_fall, reset_valid, convst_rise;
  logic cs_active, rd_fall, rd_rise, reset_in_service;

  // Power counts as good only once both late stages agree, so a drop acts on stage 1.
  assign stby_s      = stby_sync_q[1] & stby_sync_q[2];
  assign reset_s     = reset_sync_q[1];
  assign reset_fall  = reset_sync_q[2] & ~reset_sync_q[1];
  assign reset_valid = reset_fall && (reset_w_q >= RW'(RESET_MIN_TICKS));
  assign convst_rise = convst_sync_q[1] & ~convst_sync_q[2];
  // Chip select stays active through the cycle it is released so a coincident RD rise still counts.
  assign cs_active   = ~(cs_sync_q[1] & cs_sync_q[2]);
  assign rd_fall     = rd_sync_q[2] & ~rd_sync_q[1];
  assign rd_rise     = rd_sync_q[1] & ~rd_sync_q[2];
  assign reset_in_service = (state_q == ST_WAIT_RESET) || (state_q == ST_IDLE) ||
                            (state_q == ST_CONVERTING);

  always_comb begin
    stby_sync_d   = {stby_sync_q[1:0], stby};
    reset_sync_d  = {reset_sync_q[1:0], reset};
    convst_sync_d = {convst_sync_q[1:0], convst};
    cs_sync_d     = {cs_sync_q[1:0], cs_n};
    rd_sync_d     = {rd_sync_q[1:0], rd_n};

    state_d      = state_q;
    busy_d       = busy_q;
    frstdata_d   = frstdata_q;
    db_d         = db_q;
    ptr_d        = ptr_q;
    conv_count_d = conv_count_q;
    conv_cnt_d   = conv_cnt_q;
    power_cnt_d  = power_cnt_q;
    ch_d         = ch_q;

    db_oe_d = cs_active && !rd_sync_q[1];

    if (!reset_s)
      reset_w_d = '0;
    else if (reset_w_q != RW'(RESET_MIN_TICKS))
      reset_w_d = reset_w_q + 1'b1;
    else
      reset_w_d = reset_w_q;

    if (cs_active && rd_fall) begin
      db_d       = ptr_q[3] ? 16'h0000 : ch_q[ptr_q[2:0]];
      frstdata_d = (ptr_q == 4'd0);
    end
    if (rd_rise)
      frstdata_d = 1'b0;
    if (cs_active && rd_rise && !ptr_q[3])
      ptr_d = ptr_q + 4'd1;

    // Power loss outranks reset, which outranks conversion completion.
    if (!stby_s) begin
      state_d     = ST_OFF;
      busy_d      = 1'b0;
      ptr_d       = 4'd0;
      power_cnt_d = '0;
      conv_cnt_d  = '0;
    end else if (reset_valid && reset_in_service) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      ptr_d        = 4'd0;
      conv_count_d = 13'd0;
      conv_cnt_d   = '0;
      for (int i = 0; i < 8; i++) ch_d[i] = 16'h0000;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d     = ST_POWERING;
          power_cnt_d = '0;
        end
        ST_POWERING: begin
          if (power_cnt_q == PW'(POWERUP_TICKS - 1))
            state_d = ST_WAIT_RESET;
          else
            power_cnt_d = power_cnt_q + 1'b1;
        end
        ST_WAIT_RESET: state_d = ST_WAIT_RESET;
        ST_IDLE: begin
          if (convst_rise) begin
            state_d    = ST_CONVERTING;
            busy_d     = 1'b1;
            conv_cnt_d = '0;
          end
        end
        ST_CONVERTING: begin
          if (conv_cnt_q == CW'(CONV_TICKS - 1)) begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            ptr_d        = 4'd0;
            conv_count_d = conv_count_q + 13'd1;
            for (int i = 0; i < 8; i++) ch_d[i] = {3'(i), conv_count_q};
          end else begin
            conv_cnt_d = conv_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stby_sync_q   <= 3'b000;
      reset_sync_q  <= 3'b000;
      convst_sync_q <= 3'b000;
      cs_sync_q     <= 3'b111;
      rd_sync_q     <= 3'b111;
      state_q       <= ST_OFF;
      busy_q        <= 1'b0;
      frstdata_q    <= 1'b0;
      db_q          <= 16'h0000;
      db_oe_q       <= 1'b0;
      ptr_q         <= 4'd0;
      conv_count_q  <= 13'd0;
      conv_cnt_q    <= '0;
      power_cnt_q   <= '0;
      reset_w_q     <= '0;
      for (int i = 0; i < 8; i++) ch_q[i] <= 16'h0000;
    end else begin
      stby_sync_q   <= stby_sync_d;
      reset_sync_q  <= reset_sync_d;
      convst_sync_q <= convst_sync_d;
      cs_sync_q     <= cs_sync_d;
      rd_sync_q     <= rd_sync_d;
      state_q       <= state_d;
      busy_q        <= busy_d;
      frstdata_q    <= frstdata_d;
      db_q          <= db_d;
      db_oe_q       <= db_oe_d;
      ptr_q         <= ptr_d;
      conv_count_q  <= conv_count_d;
      conv_cnt_q    <= conv_cnt_d;
      power_cnt_q   <= power_cnt_d;
      reset_w_q     <= reset_w_d;
      for (int i = 0; i < 8; i++) ch_q[i] <= ch_d[i];
    end
  end

  assign busy     = busy_q;
  assign frstdata = frstdata_q;
  assign db       = db_q;
  assign db_oe    = db_oe_q;

endmodule

// File: tb/tb_ad7606_emu.sv
// Directed bench for ad7606_emu: power-up gating, reset width, conversion timing,
// channel readout, counter wrap and standby abort.
module tb_ad7606_emu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stby = 1'b0;
  logic        reset = 1'b0;
  logic        convst = 1'b0;
  logic        cs_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        busy, frstdata, db_oe;
  logic [15:0] db;

  int          checks = 0;
  int          errors = 0;
  int          width;
  int          n;
  logic        seen;
  logic        started;
  logic [15:0] rd_data;
  logic        rd_frst;
  logic        rd_oe;
  logic [15:0] exp_word;

  ad7606_emu #(
    .POWERUP_TICKS(30),
    .RESET_MIN_TICKS(2),
    .CONV_TICKS(120)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stby(stby), .reset(reset), .convst(convst),
    .cs_n(cs_n), .rd_n(rd_n), .busy(busy), .frstdata(frstdata), .db(db), .db_oe(db_oe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pulseReset(input int cycles);
    reset = 1'b1;
    tick(cycles);
    reset = 1'b0;
    tick(6);
  endtask

  // Pulses CONVST and reports whether BUSY ever rose in the following window.
  task automatic convstIgnored(output logic busy_seen);
    busy_seen = 1'b0;
    convst = 1'b1;
    tick(3);
    convst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
  endtask

  task automatic startConv(output logic ok);
    ok = 1'b0;
    convst = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (i == 2) convst = 1'b0;
      if (busy === 1'b1) ok = 1'b1;
    end
    convst = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic convWidth(input bit overlap, output int w);
    logic ok;
    int   c;
    startConv(ok);
    c = 0;
    while (busy === 1'b1 && c < 400) begin
      if (overlap && c == 20) convst = 1'b1;
      if (overlap && c == 24) convst = 1'b0;
      tick(1);
      c++;
    end
    convst = 1'b0;
    w = ok ? c : 0;
    tick(4);
  endtask

  task automatic readWord(output logic [15:0] d, output logic f, output logic oe);
    cs_n = 1'b0;
    rd_n = 1'b0;
    tick(6);
    d  = db;
    f  = frstdata;
    oe = db_oe;
    rd_n = 1'b1;
    tick(6);
    cs_n = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_frstdata", 32'(frstdata), 32'h0);
    checkOutput("reset_db", 32'(db), 32'h0);
    checkOutput("reset_db_oe", 32'(db_oe), 32'h0);
    rst_n = 1'b1;
    tick(2);

    stby = 1'b1;
    tick(5);
    convstIgnored(seen);
    checkOutput("powering_convst", 32'(seen), 32'h0);
    tick(40);
    convstIgnored(seen);
    checkOutput("wait_reset_convst", 32'(seen), 32'h0);

    pulseReset(1);
    convstIgnored(seen);
    checkOutput("short_reset_convst", 32'(seen), 32'h0);
    pulseReset(2);
    convWidth(1'b0, width);
    checkOutput("first_conv_width", 32'(width), 32'd120);

    for (int i = 0; i < 8; i++) begin
      readWord(rd_data, rd_frst, rd_oe);
      exp_word = {3'(i), 13'h0000};
      checkOutput($sformatf("read_ch%0d_db", i), 32'(rd_data), 32'(exp_word));
      checkOutput($sformatf("read_ch%0d_frst", i), 32'(rd_frst), (i == 0) ? 32'h1 : 32'h0);
      if (i == 0) checkOutput("read_db_oe", 32'(rd_oe), 32'h1);
    end
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("read_ninth_db", 32'(rd_data), 32'h0000);
    checkOutput("read_ninth_frst", 32'(rd_frst), 32'h0);
    checkOutput("idle_db_oe", 32'(db_oe), 32'h0);

    convWidth(1'b1, width);
    checkOutput("overlap_width", 32'(width), 32'd120);
    for (int i = 0; i < 4; i++) begin
      readWord(rd_data, rd_frst, rd_oe);
      if (i == 0) checkOutput("conv2_ch0", 32'(rd_data), 32'h0001);
      if (i == 3) checkOutput("conv2_ch3", 32'(rd_data), 32'h6001);
    end

    startConv(started);
    checkOutput("conv3_started", 32'(started), 32'h1);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("busy_read_ch4", 32'(rd_data), 32'h8001);
    checkOutput("busy_during_read", 32'(busy), 32'h1);
    waitIdle(n);
    checkOutput("conv3_finished", 32'(n < 400), 32'h1);
    tick(4);

    force dut.conv_count_q = 13'h1FFF;
    tick(2);
    release dut.conv_count_q;
    convWidth(1'b0, width);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("wrap_max_ch0", 32'(rd_data), 32'h1FFF);
    convWidth(1'b0, width);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("wrap_zero_ch0", 32'(rd_data), 32'h0000);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("wrap_zero_ch1", 32'(rd_data), 32'h2000);

    startConv(started);
    tick(30);
    stby = 1'b0;
    tick(3);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    tick(10);
    stby = 1'b1;
    tick(50);
    convstIgnored(seen);
    checkOutput("post_abort_convst", 32'(seen), 32'h0);
    pulseReset(5);
    convWidth(1'b0, width);
    checkOutput("repower_width", 32'(width), 32'd120);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("repower_ch0", 32'(rd_data), 32'h0000);
    checkOutput("repower_frst", 32'(rd_frst), 32'h1);
    readWord(rd_data, rd_frst, rd_oe);
    checkOutput("repower_ch1", 32'(rd_data), 32'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
